// File: rtl/ext_bus_mailbox_pkg.sv
// ext_bus_mailbox_pkg: register map and bit positions for the ext_bus_mailbox
// CPU register window.
package ext_bus_mailbox_pkg;

  // register window, selected by rs
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RXCNT  = 2'd3;

  // STATUS bits
  localparam int ST_RX_NE = 0;  // RX non-empty
  localparam int ST_TX_NF = 1;  // TX not full
  localparam int ST_TX_E  = 2;  // TX empty
  localparam int ST_OVR   = 3;  // sticky: DATA write while TX full
  localparam int ST_UND   = 4;  // sticky: DATA read while RX empty
  localparam int ST_IRQ   = 7;  // interrupt pending

  // CTRL bits
  localparam int CT_RX_IE  = 0;
  localparam int CT_TX_IE  = 1;
  localparam int CT_FLUSH  = 7;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock byte FIFO, DEPTH entries (power of two, 2..256).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, resb       clock, async active-low reset
//   push, din       write a byte (ignored when full)
//   pop             drop the head byte (ignored when empty)
//   clear           empty the FIFO; wins over same-cycle push/pop
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH
//   head            oldest byte (undefined when empty)
module sync_fifo
  import ext_bus_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resb,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [7:0]               din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // storage needs no reset: head is only meaningful when non-empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ext_bus_mailbox.sv
// ext_bus_mailbox: 65C02-style bus responder exposing a 4-register window
// (DATA, STATUS, CTRL, RXCNT) that bridges CPU bytes to a host TX stream and
// host RX stream bytes back to the CPU through two sync_fifo instances.
// Optional feature macro: EXT_BUS_MAILBOX_IRQ_EN enables the level interrupt
// on irqb; without it irqb is tied high and STATUS[7] reads 0.
// Ports:
//   clk, resb                     clock, async active-low reset
//   phi2, csb, rwb, rs, data_in   CPU bus; commits on the phi2 falling edge
//   data_out, data_oe             registered read data and its drive enable
//   irqb                          active-low level interrupt
//   tx_data/tx_valid/tx_ready     CPU-to-host byte stream
//   rx_data/rx_valid/rx_ready     host-to-CPU byte stream
module ext_bus_mailbox
  import ext_bus_mailbox_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resb,
  input  logic       phi2,
  input  logic       csb,
  input  logic       rwb,
  input  logic [1:0] rs,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       irqb,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          phi2_q, fall, acc;
  logic          wr_data, rd_data, rd_status, wr_ctrl, flush;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rx_head;
  logic          ovr_q, und_q;
  logic [1:0]    ctrl_q;
  logic          irq_pend;
  logic [7:0]    status, rd_mux;
  logic          unused_bits;

  // bus commit: the clk edge on which phi2 is seen falling
  assign fall      = phi2_q & ~phi2;
  assign acc       = fall & ~csb;
  assign wr_data   = acc & ~rwb & (rs == REG_DATA);
  assign rd_data   = acc &  rwb & (rs == REG_DATA);
  assign rd_status = acc &  rwb & (rs == REG_STATUS);
  assign wr_ctrl   = acc & ~rwb & (rs == REG_CTRL);
  assign flush     = wr_ctrl & data_in[CT_FLUSH];

  assign tx_push  = wr_data & ~tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign rx_pop   = rd_data & ~rx_empty;
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;

  // gated by resb so the bus is released the moment reset hits mid-access
  assign data_oe  = resb & phi2 & ~csb & rwb;

  sync_fifo #(.DEPTH(DEPTH)) u_tx (
    .clk(clk), .resb(resb), .push(tx_push), .pop(tx_pop), .clear(flush),
    .din(data_in), .full(tx_full), .empty(tx_empty), .count(tx_count),
    .head(tx_data)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_rx (
    .clk(clk), .resb(resb), .push(rx_push), .pop(rx_pop), .clear(flush),
    .din(rx_data), .full(rx_full), .empty(rx_empty), .count(rx_count),
    .head(rx_head)
  );

  assign unused_bits = ^{data_in[6:2], tx_count};

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      phi2_q <= 1'b0;
      ovr_q  <= 1'b0;
      und_q  <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      phi2_q <= phi2;
      // the STATUS value already latched in data_out shows pre-clear bits
      if (rd_status) begin
        ovr_q <= 1'b0;
        und_q <= 1'b0;
      end else begin
        if (wr_data & tx_full)  ovr_q <= 1'b1;
        if (rd_data & rx_empty) und_q <= 1'b1;
      end
      if (wr_ctrl) ctrl_q <= data_in[1:0];
    end
  end

`ifdef EXT_BUS_MAILBOX_IRQ_EN
  assign irq_pend = (ctrl_q[CT_RX_IE] & ~rx_empty) | (ctrl_q[CT_TX_IE] & tx_empty);

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) irqb <= 1'b1;
    else       irqb <= ~irq_pend;
  end
`else
  assign irq_pend = 1'b0;
  assign irqb     = 1'b1;
`endif

  always_comb begin
    status           = '0;
    status[ST_RX_NE] = ~rx_empty;
    status[ST_TX_NF] = ~tx_full;
    status[ST_TX_E]  = tx_empty;
    status[ST_OVR]   = ovr_q;
    status[ST_UND]   = und_q;
    status[ST_IRQ]   = irq_pend;
  end

  always_comb begin
    rd_mux = '0;
    case (rs)
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = {6'b0, ctrl_q};
      REG_RXCNT:  rd_mux = 8'(rx_count);
      default:    rd_mux = '0;
    endcase
  end

  // tracks the register mux through the access phase, holds once phi2 drops
  always_ff @(posedge clk or negedge resb) begin
    if (!resb)                    data_out <= 8'h00;
    else if (phi2 & ~csb & rwb)   data_out <= rd_mux;
  end

endmodule

// File: tb/tb_ext_bus_mailbox.sv
module tb_ext_bus_mailbox;

  localparam int DEPTH = 8;
  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_RXCNT = 2'd3;

  logic       clk = 1'b0;
  logic       resb = 1'b0;
  logic       phi2 = 1'b0, csb = 1'b1, rwb = 1'b1;
  logic [1:0] rs = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, irqb;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ext_bus_mailbox #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resb(resb), .phi2(phi2), .csb(csb), .rwb(rwb), .rs(rs),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe), .irqb(irqb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // One bus cycle: two clk of phi2 high, then phi2 low for the commit edge.
  // Optionally drives a host RX push exactly on the commit edge.
  // Returns at the negedge right after the commit edge.
  task automatic bus(input logic rw, input logic [1:0] a, input logic [7:0] d,
                     input logic hp, input logic [7:0] hd, output logic [7:0] q);
    @(negedge clk);
    phi2 = 1'b1; csb = 1'b0; rwb = rw; rs = a; data_in = d;
    @(negedge clk);
    @(negedge clk);
    q = data_out;
    phi2 = 1'b0;
    if (hp) begin rx_valid = 1'b1; rx_data = hd; end
    @(negedge clk);
    csb = 1'b1; rwb = 1'b1; rx_valid = 1'b0;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(1'b0, a, d, 1'b0, 8'h00, q);
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] q);
    bus(1'b1, a, 8'h00, 1'b0, 8'h00, q);
  endtask

  task automatic host_push(input logic [7:0] d);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] q;
    repeat (2) @(negedge clk);
    vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL reset_data_out got %h want 00", data_out); end
    vecs++; if (data_oe !== 1'b0)   begin errs++; $display("FAIL reset_data_oe got %b want 0", data_oe); end
    vecs++; if (irqb !== 1'b1)      begin errs++; $display("FAIL reset_irqb got %b want 1", irqb); end
    vecs++; if (tx_valid !== 1'b0)  begin errs++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    vecs++; if (rx_ready !== 1'b1)  begin errs++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
    resb = 1'b1;
    cpu_rd(A_CTRL, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL reset_ctrl got %h want 00", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h06) begin errs++; $display("FAIL reset_status got %h want 06", q); end
  endtask

  task automatic test_tx;
    logic [7:0] q;
    tx_ready = 1'b1;
    cpu_wr(A_DATA, 8'hA5);
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errs++; $display("FAIL tx_first got v=%b d=%h want v=1 d=a5", tx_valid, tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL tx_first_pop got %b want 0", tx_valid); end
    cpu_wr(A_DATA, 8'h3C);
    vecs++; if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin errs++; $display("FAIL tx_second got v=%b d=%h want v=1 d=3c", tx_valid, tx_data); end
    @(negedge clk);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL tx_second_pop got %b want 0", tx_valid); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h06) begin errs++; $display("FAIL tx_status got %h want 06", q); end
  endtask

  task automatic test_rx;
    logic [7:0] q;
    host_push(8'h11);
    host_push(8'h22);
    cpu_rd(A_RXCNT, q);
    vecs++; if (q !== 8'h02) begin errs++; $display("FAIL rx_cnt2 got %h want 02", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h07) begin errs++; $display("FAIL rx_status got %h want 07", q); end
    cpu_rd(A_DATA, q);
    vecs++; if (q !== 8'h11) begin errs++; $display("FAIL rx_byte0 got %h want 11", q); end
    cpu_rd(A_DATA, q);
    vecs++; if (q !== 8'h22) begin errs++; $display("FAIL rx_byte1 got %h want 22", q); end
    cpu_rd(A_RXCNT, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL rx_cnt0 got %h want 00", q); end
  endtask

  task automatic test_ovr;
    logic [7:0] q;
    tx_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) cpu_wr(A_DATA, 8'h40 + 8'(i));
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h08) begin errs++; $display("FAIL ovr_status1 got %h want 08", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL ovr_status2 got %h want 00", q); end
    for (int i = 0; i < DEPTH; i++) begin
      vecs++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h40 + 8'(i)) begin
        errs++; $display("FAIL ovr_drain%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, 8'h40 + 8'(i));
      end
      tx_ready = 1'b1;
      @(negedge clk);
    end
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL ovr_lost got %b want 0", tx_valid); end
  endtask

  task automatic test_und;
    logic [7:0] q;
    cpu_rd(A_DATA, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL und_data got %h want 00", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h16) begin errs++; $display("FAIL und_status got %h want 16", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h06) begin errs++; $display("FAIL und_cleared got %h want 06", q); end
    host_push(8'h77);
    bus(1'b1, A_DATA, 8'h00, 1'b1, 8'h88, q);
    vecs++; if (q !== 8'h77) begin errs++; $display("FAIL simul_data got %h want 77", q); end
    cpu_rd(A_RXCNT, q);
    vecs++; if (q !== 8'h01) begin errs++; $display("FAIL simul_cnt got %h want 01", q); end
    cpu_rd(A_DATA, q);
    vecs++; if (q !== 8'h88) begin errs++; $display("FAIL simul_next got %h want 88", q); end
  endtask

  task automatic test_irq;
    logic [7:0] q;
`ifdef EXT_BUS_MAILBOX_IRQ_EN
    cpu_wr(A_CTRL, 8'h01);
    @(negedge clk);
    vecs++; if (irqb !== 1'b1) begin errs++; $display("FAIL irq_idle got %b want 1", irqb); end
    host_push(8'h5A);
    @(negedge clk);
    vecs++; if (irqb !== 1'b0) begin errs++; $display("FAIL irq_rx_assert got %b want 0", irqb); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h87) begin errs++; $display("FAIL irq_status got %h want 87", q); end
    cpu_rd(A_DATA, q);
    vecs++; if (q !== 8'h5A) begin errs++; $display("FAIL irq_data got %h want 5a", q); end
    vecs++; if (irqb !== 1'b0) begin errs++; $display("FAIL irq_latency got %b want 0", irqb); end
    @(negedge clk);
    vecs++; if (irqb !== 1'b1) begin errs++; $display("FAIL irq_rx_release got %b want 1", irqb); end
    cpu_wr(A_CTRL, 8'h02);
    @(negedge clk);
    vecs++; if (irqb !== 1'b0) begin errs++; $display("FAIL irq_tx_empty got %b want 0", irqb); end
    cpu_wr(A_CTRL, 8'h00);
    @(negedge clk);
    vecs++; if (irqb !== 1'b1) begin errs++; $display("FAIL irq_off got %b want 1", irqb); end
`else
    host_push(8'h5A);
    cpu_wr(A_CTRL, 8'h03);
    @(negedge clk);
    vecs++; if (irqb !== 1'b1) begin errs++; $display("FAIL irq_tied got %b want 1", irqb); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h07) begin errs++; $display("FAIL irq_status got %h want 07", q); end
    cpu_rd(A_CTRL, q);
    vecs++; if (q !== 8'h03) begin errs++; $display("FAIL irq_ctrl_rw got %h want 03", q); end
    cpu_rd(A_DATA, q);
    vecs++; if (q !== 8'h5A) begin errs++; $display("FAIL irq_data got %h want 5a", q); end
    cpu_wr(A_CTRL, 8'h00);
`endif
  endtask

  task automatic test_flush;
    logic [7:0] q;
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_wr(A_DATA, 8'hB0 + 8'(i));
      host_push(8'hC0 + 8'(i));
    end
    cpu_rd(A_RXCNT, q);
    vecs++; if (q !== 8'h03) begin errs++; $display("FAIL flush_pre_cnt got %h want 03", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h03) begin errs++; $display("FAIL flush_pre_status got %h want 03", q); end
    // host push on the flush edge must lose to the flush
    bus(1'b0, A_CTRL, 8'h80, 1'b1, 8'hEE, q);
    vecs++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL flush_tx got %b want 0", tx_valid); end
    cpu_rd(A_RXCNT, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL flush_rx_cnt got %h want 00", q); end
    cpu_rd(A_CTRL, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL flush_ctrl got %h want 00", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h06) begin errs++; $display("FAIL flush_status got %h want 06", q); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] q;
    tx_ready = 1'b0;
    cpu_wr(A_DATA, 8'h99);
    host_push(8'h33);
    @(negedge clk);
    phi2 = 1'b1; csb = 1'b0; rwb = 1'b1; rs = A_DATA;
    @(negedge clk);
    @(negedge clk);
    vecs++; if (data_out !== 8'h33 || data_oe !== 1'b1) begin errs++; $display("FAIL mid_pre got d=%h oe=%b want d=33 oe=1", data_out, data_oe); end
    resb = 1'b0;
    #1;
    vecs++; if (data_out !== 8'h00) begin errs++; $display("FAIL mid_data_out got %h want 00", data_out); end
    vecs++; if (data_oe !== 1'b0)   begin errs++; $display("FAIL mid_data_oe got %b want 0", data_oe); end
    vecs++; if (tx_valid !== 1'b0)  begin errs++; $display("FAIL mid_tx_valid got %b want 0", tx_valid); end
    vecs++; if (rx_ready !== 1'b1 || irqb !== 1'b1) begin errs++; $display("FAIL mid_rdy_irq got r=%b i=%b want 1 1", rx_ready, irqb); end
    @(negedge clk);
    phi2 = 1'b0;
    @(negedge clk);
    csb = 1'b1;
    @(negedge clk);
    resb = 1'b1;
    cpu_rd(A_RXCNT, q);
    vecs++; if (q !== 8'h00) begin errs++; $display("FAIL mid_rxcnt got %h want 00", q); end
    cpu_rd(A_STAT, q);
    vecs++; if (q !== 8'h06) begin errs++; $display("FAIL mid_status got %h want 06", q); end
  endtask

  initial begin
    test_reset;
    test_tx;
    test_rx;
    test_ovr;
    test_und;
    test_irq;
    test_flush;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
